// File: rtl/uart_cmd_framer.sv
// Turns UART receiver byte strobes into 9-byte checksummed command frames
// (SYNC OP A0 A1 D0 D1 D2 D3 CHK) and presents them on a valid/ready port.
//
// state  | meaning
// S_SYNC | hunting for the sync byte
// S_OP   | waiting for opcode byte
// S_A0   | waiting for address low byte
// S_A1   | waiting for address high byte
// S_D0   | waiting for data byte 0 (LSB)
// S_D1   | waiting for data byte 1
// S_D2   | waiting for data byte 2
// S_D3   | waiting for data byte 3 (MSB)
// S_CHK  | waiting for checksum byte
// S_HOLD | command presented, waiting for handshake
module uart_cmd_framer #(
   parameter int          TIMEOUT_CLKS = 256,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [7:0]  i_rx_data,
   input  logic        i_rx_data_valid,
   output logic        o_cmd_valid,
   input  logic        i_cmd_ready,
   output logic [7:0]  o_cmd_op,
   output logic [15:0] o_cmd_addr,
   output logic [31:0] o_cmd_data,
   output logic        o_err_checksum,
   output logic        o_err_timeout,
   output logic        o_err_overrun,
   output logic        o_busy
);

   localparam int              CNT_W    = $clog2(TIMEOUT_CLKS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);

   typedef enum logic [3:0] {
      S_SYNC, S_OP, S_A0, S_A1, S_D0, S_D1, S_D2, S_D3, S_CHK, S_HOLD
   } state_t;

   state_t           state, state_nxt;
   logic [7:0]       sum, sum_nxt, sum_byte;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [7:0]       op_nxt;
   logic [15:0]      addr_nxt;
   logic [31:0]      data_nxt;
   logic             err_cs_nxt, err_to_nxt, err_ov_nxt;
   logic             is_sync;

   assign sum_byte = sum + i_rx_data;
   assign is_sync  = i_rx_data_valid && (i_rx_data == SYNC_BYTE);

   always_comb begin
      state_nxt  = state;
      sum_nxt    = sum;
      cnt_nxt    = cnt;
      op_nxt     = o_cmd_op;
      addr_nxt   = o_cmd_addr;
      data_nxt   = o_cmd_data;
      err_cs_nxt = 1'b0;
      err_to_nxt = 1'b0;
      err_ov_nxt = 1'b0;
      unique case (state)
         S_SYNC: begin
            if (is_sync) begin
               state_nxt = S_OP;
               sum_nxt   = '0;
               cnt_nxt   = '0;
            end
         end
         S_HOLD: begin
            // the handshake cycle doubles as an S_SYNC cycle for incoming bytes
            if (o_cmd_valid && i_cmd_ready) begin
               state_nxt = S_SYNC;
               if (is_sync) begin
                  state_nxt = S_OP;
                  sum_nxt   = '0;
                  cnt_nxt   = '0;
               end
            end else if (i_rx_data_valid) begin
               err_ov_nxt = 1'b1;
            end
         end
         default: begin
            if (i_rx_data_valid) begin
               cnt_nxt = '0;
               sum_nxt = sum_byte;
               case (state)
                  S_OP: begin op_nxt = i_rx_data;             state_nxt = S_A0; end
                  S_A0: begin addr_nxt[7:0]   = i_rx_data;    state_nxt = S_A1; end
                  S_A1: begin addr_nxt[15:8]  = i_rx_data;    state_nxt = S_D0; end
                  S_D0: begin data_nxt[7:0]   = i_rx_data;    state_nxt = S_D1; end
                  S_D1: begin data_nxt[15:8]  = i_rx_data;    state_nxt = S_D2; end
                  S_D2: begin data_nxt[23:16] = i_rx_data;    state_nxt = S_D3; end
                  S_D3: begin data_nxt[31:24] = i_rx_data;    state_nxt = S_CHK; end
                  S_CHK: begin
                     if (sum_byte == 8'd0) begin
                        state_nxt = S_HOLD;
                     end else begin
                        err_cs_nxt = 1'b1;
                        state_nxt  = S_SYNC;
                     end
                  end
                  default: state_nxt = S_SYNC;
               endcase
            end else if (cnt == CNT_LAST) begin
               err_to_nxt = 1'b1;
               state_nxt  = S_SYNC;
               cnt_nxt    = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state          <= S_SYNC;
         sum            <= '0;
         cnt            <= '0;
         o_cmd_op       <= '0;
         o_cmd_addr     <= '0;
         o_cmd_data     <= '0;
         o_cmd_valid    <= 1'b0;
         o_err_checksum <= 1'b0;
         o_err_timeout  <= 1'b0;
         o_err_overrun  <= 1'b0;
         o_busy         <= 1'b0;
      end else begin
         state          <= state_nxt;
         sum            <= sum_nxt;
         cnt            <= cnt_nxt;
         o_cmd_op       <= op_nxt;
         o_cmd_addr     <= addr_nxt;
         o_cmd_data     <= data_nxt;
         o_cmd_valid    <= (state_nxt == S_HOLD);
         o_err_checksum <= err_cs_nxt;
         o_err_timeout  <= err_to_nxt;
         o_err_overrun  <= err_ov_nxt;
         o_busy         <= (state_nxt != S_SYNC);
      end
   end

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Bench for uart_cmd_framer: directed scenarios plus random traffic, checked
// every cycle against a byte-queue reference model.
module tb_uart_cmd_framer;

   localparam int         T  = 16;
   localparam logic [7:0] SB = 8'hA5;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic [7:0]  i_rx_data = 8'h00;
   logic        i_rx_data_valid = 1'b0;
   logic        i_cmd_ready = 1'b0;
   logic        o_cmd_valid;
   logic [7:0]  o_cmd_op;
   logic [15:0] o_cmd_addr;
   logic [31:0] o_cmd_data;
   logic        o_err_checksum, o_err_timeout, o_err_overrun, o_busy;

   always #5 i_clk = ~i_clk;

   uart_cmd_framer #(.TIMEOUT_CLKS(T), .SYNC_BYTE(SB)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_rx_data(i_rx_data), .i_rx_data_valid(i_rx_data_valid),
      .o_cmd_valid(o_cmd_valid), .i_cmd_ready(i_cmd_ready),
      .o_cmd_op(o_cmd_op), .o_cmd_addr(o_cmd_addr), .o_cmd_data(o_cmd_data),
      .o_err_checksum(o_err_checksum), .o_err_timeout(o_err_timeout),
      .o_err_overrun(o_err_overrun), .o_busy(o_busy)
   );

   int total = 0;
   int bad   = 0;

   // model: mode 0 = hunting, 1 = collecting frame body, 2 = holding a command
   int          m_mode = 0;
   logic [7:0]  m_q[$];
   int          m_idle = 0;
   logic        m_valid = 0, m_busy = 0, m_ecs = 0, m_eto = 0, m_eov = 0;
   logic [7:0]  m_op = 0;
   logic [15:0] m_addr = 0;
   logic [31:0] m_data = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model(input logic v, input logic [7:0] d, input logic rdy, input logic r);
      m_ecs = 0; m_eto = 0; m_eov = 0;
      if (r) begin
         m_mode = 0; m_q.delete(); m_idle = 0;
         m_op = 0; m_addr = 0; m_data = 0;
      end else begin
         case (m_mode)
            0: if (v && d == SB) begin m_mode = 1; m_q.delete(); m_idle = 0; end
            2: begin
               if (m_valid && rdy) begin
                  m_mode = 0;
                  if (v && d == SB) begin m_mode = 1; m_q.delete(); m_idle = 0; end
               end else if (v) begin
                  m_eov = 1;
               end
            end
            default: begin
               if (v) begin
                  m_q.push_back(d);
                  m_idle = 0;
                  if (m_q.size() == 8) begin
                     int s;
                     s = 0;
                     foreach (m_q[i]) s += int'(m_q[i]);
                     if (s % 256 == 0) begin
                        m_op   = m_q[0];
                        m_addr = {m_q[2], m_q[1]};
                        m_data = {m_q[6], m_q[5], m_q[4], m_q[3]};
                        m_mode = 2;
                     end else begin
                        m_ecs  = 1;
                        m_mode = 0;
                     end
                  end
               end else begin
                  m_idle++;
                  if (m_idle == T) begin m_eto = 1; m_mode = 0; m_idle = 0; end
               end
            end
         endcase
      end
      m_valid = (m_mode == 2);
      m_busy  = (m_mode != 0);
   endtask

   task automatic step(input logic v, input logic [7:0] d, input logic rdy, input logic r);
      @(negedge i_clk);
      i_rx_data_valid = v;
      i_rx_data       = d;
      i_cmd_ready     = rdy;
      i_rst           = r;
      @(posedge i_clk);
      model(v, d, rdy, r);
      #1;
      chk("valid",  32'(o_cmd_valid),    32'(m_valid));
      chk("busy",   32'(o_busy),         32'(m_busy));
      chk("err_cs", 32'(o_err_checksum), 32'(m_ecs));
      chk("err_to", 32'(o_err_timeout),  32'(m_eto));
      chk("err_ov", 32'(o_err_overrun),  32'(m_eov));
      if (m_valid) begin
         chk("op",   32'(o_cmd_op),   32'(m_op));
         chk("addr", 32'(o_cmd_addr), 32'(m_addr));
         chk("data", o_cmd_data,      m_data);
      end
   endtask

   task automatic send(input logic [7:0] fr[9], input int first, input int last, input logic rdy);
      for (int i = first; i <= last; i++) step(1'b1, fr[i], rdy, 1'b0);
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, rdy, 1'b0);
   endtask

   initial begin
      logic [7:0] good[9];
      logic [7:0] badf[9];
      logic [7:0] fr[9];
      logic [7:0] acc;
      int         gap;
      good = '{8'hA5, 8'h01, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h81};
      badf = good;
      badf[8] = 8'h80;

      step(1'b0, 8'h00, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("rst_op",   32'(o_cmd_op),   32'h0);
      chk("rst_addr", 32'(o_cmd_addr), 32'h0);
      chk("rst_data", o_cmd_data,      32'h0);

      // good frame, ready held high
      send(good, 0, 8, 1'b1);
      chk("good_valid", 32'(o_cmd_valid), 32'h1);
      chk("good_op",    32'(o_cmd_op),    32'h01);
      chk("good_addr",  32'(o_cmd_addr),  32'h1234);
      chk("good_data",  o_cmd_data,       32'hDEADBEEF);
      idle(2, 1'b1);
      chk("good_done", 32'(o_cmd_valid), 32'h0);

      // bad checksum then good frame
      send(badf, 0, 8, 1'b1);
      chk("bad_cs_pulse", 32'(o_err_checksum), 32'h1);
      idle(1, 1'b1);
      send(good, 0, 8, 1'b1);
      idle(2, 1'b1);

      // garbage then good frame
      step(1'b1, 8'h00, 1'b1, 1'b0);
      step(1'b1, 8'hFF, 1'b1, 1'b0);
      step(1'b1, 8'h12, 1'b1, 1'b0);
      chk("garbage_idle", 32'(o_busy), 32'h0);
      send(good, 0, 8, 1'b1);
      idle(2, 1'b1);

      // timeout after a gap of T clocks
      send(good, 0, 2, 1'b1);
      idle(T, 1'b1);
      chk("to_pulse", 32'(o_err_timeout), 32'h1);
      chk("to_busy",  32'(o_busy),        32'h0);
      idle(2, 1'b1);

      // a gap of T-1 clocks is tolerated
      send(good, 0, 2, 1'b1);
      idle(T - 1, 1'b1);
      send(good, 3, 8, 1'b1);
      chk("edge_valid", 32'(o_cmd_valid), 32'h1);
      idle(2, 1'b1);

      // backpressure, overrun, handshake with a sync byte in the same cycle
      send(good, 0, 8, 1'b0);
      idle(3, 1'b0);
      step(1'b1, 8'h55, 1'b0, 1'b0);
      chk("ovr_pulse", 32'(o_err_overrun), 32'h1);
      chk("ovr_op",    32'(o_cmd_op),      32'h01);
      chk("ovr_addr",  32'(o_cmd_addr),    32'h1234);
      chk("ovr_data",  o_cmd_data,         32'hDEADBEEF);
      step(1'b1, SB, 1'b1, 1'b0);
      chk("hs_valid", 32'(o_cmd_valid), 32'h0);
      chk("hs_busy",  32'(o_busy),      32'h1);
      send(good, 1, 8, 1'b0);
      chk("hs_frame", 32'(o_cmd_valid), 32'h1);
      idle(1, 1'b1);
      idle(1, 1'b1);

      // reset while waiting for D1
      send(good, 0, 4, 1'b1);
      step(1'b0, 8'h00, 1'b1, 1'b1);
      chk("mrst_busy", 32'(o_busy),     32'h0);
      chk("mrst_op",   32'(o_cmd_op),   32'h0);
      chk("mrst_addr", 32'(o_cmd_addr), 32'h0);
      chk("mrst_data", o_cmd_data,      32'h0);
      send(good, 0, 8, 1'b1);
      idle(2, 1'b1);

      // random traffic
      for (int f = 0; f < 150; f++) begin
         fr[0] = SB;
         acc = 8'h00;
         for (int i = 1; i < 8; i++) begin
            fr[i] = 8'($urandom);
            acc   = acc + fr[i];
         end
         fr[8] = 8'h00 - acc;
         if ($urandom_range(0, 4) == 0) fr[8] = fr[8] + 8'($urandom_range(1, 255));
         if ($urandom_range(0, 3) == 0) begin
            for (int g = 0; g < int'($urandom_range(1, 4)); g++)
               step(1'b1, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
         end
         for (int i = 0; i < 9; i++) begin
            if ($urandom_range(0, 15) == 0) gap = int'($urandom_range(T - 2, T + 1));
            else gap = int'($urandom_range(0, 2));
            for (int k = 0; k < gap; k++) step(1'b0, 8'h00, 1'($urandom_range(0, 1)), 1'b0);
            if ($urandom_range(0, 80) == 0) step(1'b0, 8'h00, 1'b0, 1'b1);
            step(1'b1, fr[i], 1'($urandom_range(0, 1)), 1'b0);
         end
         idle(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
      idle(4, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_cmd_framer.md
# uart_cmd_framer

Byte-stream controller that sits directly behind the UART receiver and turns its one-cycle `o_data`/`o_data_valid` byte pulses into fixed-length, checksummed command frames. It hunts for a sync byte, assembles opcode/address/data fields, validates an 8-bit checksum, and presents each good command on a valid/ready interface to the register/command layer. It resynchronises on malformed, stalled or overrun traffic and reports each such event as a one-cycle error pulse.

## Interface
- `TIMEOUT_CLKS`, default 256: maximum idle clocks allowed between bytes inside a frame. Must be ≥ 2.
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `i_clk` input 1: clock.
- `i_rst` input 1: reset; **one clock; reset is synchronous and active-high**.
- `i_rx_data` input 8: received byte, sampled only when `i_rx_data_valid` = 1.
- `i_rx_data_valid` input 1: one-cycle byte strobe from the receiver.
- `o_cmd_valid` output 1: command available.
- `i_cmd_ready` input 1: consumer accepts the command.
- `o_cmd_op` output 8: opcode.
- `o_cmd_addr` output 16: address.
- `o_cmd_data` output 32: data.
- `o_err_checksum` output 1: one-cycle pulse when a frame is discarded for bad checksum.
- `o_err_timeout` output 1: one-cycle pulse when a partial frame is abandoned.
- `o_err_overrun` output 1: one-cycle pulse when a byte is dropped while a command is pending.
- `o_busy` output 1: high in any state other than S_SYNC.

## Operation
- Frame format, 9 bytes: SYNC, OP, A0, A1, D0, D1, D2, D3, CHK.
  - Address and data fields are little-endian: `addr = {A1,A0}`, `data = {D3,D2,D1,D0}`.
  - A frame is good if `(OP+A0+A1+D0+D1+D2+D3+CHK) mod 256 == 0`.
  - Use an 8-bit wrapping running sum, cleared on entry to S_OP.
- States and transitions:
  - S_SYNC → S_OP on a byte equal to SYNC_BYTE. Any other byte is discarded silently.
  - S_OP, S_A0, S_A1, S_D0, S_D1, S_D2, S_D3: each accepted byte is stored in its field, added to the sum, and advances the state.
  - S_CHK: on the byte, if `sum+byte == 0` go to S_HOLD and assert `o_cmd_valid`. Otherwise pulse `o_err_checksum` and go to S_SYNC.
  - S_HOLD: hold `o_cmd_*` stable while `o_cmd_valid` = 1. On `o_cmd_valid && i_cmd_ready`, deassert `o_cmd_valid` the next cycle and go to S_SYNC.
- Overrun: a byte arriving in S_HOLD in any cycle without the handshake is dropped and pulses `o_err_overrun`.
  - Exception: a byte in the handshake cycle itself is processed as an S_SYNC byte. If it equals SYNC_BYTE, the next state is S_OP.
- Timeout: a counter of width `$clog2(TIMEOUT_CLKS)` runs only in states S_OP..S_CHK.
  - It clears on every accepted byte and on entry to S_OP.
  - If it equals `TIMEOUT_CLKS-1` and no byte arrives that cycle: pulse `o_err_timeout`, go to S_SYNC, clear the counter.
  - A byte arriving on that same cycle wins; no timeout occurs.
- Opcode values are not interpreted. All opcodes pass through.

## Timing
- Reset values:
  - State S_SYNC.
  - `o_cmd_valid`, all three error pulses and `o_busy` = 0.
  - `o_cmd_op`, `o_cmd_addr`, `o_cmd_data`, running sum and timeout counter = 0.
- Reset mid-frame or mid-hold aborts the frame with no error pulse. `o_cmd_valid` drops the cycle after `i_rst` is sampled high.
- Latency: `o_cmd_valid` rises on the clock edge that samples the CHK byte, so it is visible in the cycle after the CHK strobe. `o_err_checksum` follows the same timing.
- Each error pulse lasts exactly one cycle and is registered. Pulses coincide with the state change.
- `o_cmd_*` fields may change only while `o_cmd_valid` = 0.
- Throughput: back-to-back byte strobes on consecutive cycles must be accepted.
- `o_busy` is registered. It is high from the cycle after SYNC is accepted until the cycle after the return to S_SYNC.

## Test plan
- Good frame: A5 01 34 12 EF BE AD DE 81 with `i_cmd_ready` = 1 → one `o_cmd_valid` cycle with op=0x01, addr=0x1234, data=0xDEADBEEF, and no error pulses.
- Bad checksum: same frame with CHK = 0x80 → `o_err_checksum` pulses once, `o_cmd_valid` never rises. A following good frame is then accepted.
- Garbage and resync: bytes 00 FF 12, then the good frame → no errors, exactly one command.
- Timeout: A5 01 34, then an idle gap of `TIMEOUT_CLKS` clocks → `o_err_timeout` pulses exactly once and `o_busy` falls. Check the boundary too: a gap of `TIMEOUT_CLKS-1` clocks must not time out.
- Backpressure and overrun: deliver the good frame with `i_cmd_ready` = 0, then send byte 0x55 → `o_err_overrun` pulses and the fields stay stable. Raising ready gives one handshake. A5 sent in the handshake cycle starts a new frame.
- Reset during S_D1 → all outputs 0 next cycle. A subsequent good frame decodes correctly.
